// File: rtl/spu_decode_stage.sv
// spu_decode_stage: decode stage with bypassed 3-read register file, immediate builder
// and busy-bit scoreboard that stalls RAW/WAW hazards against in-flight writes.
module spu_decode_stage #(
   parameter int DATA_W   = 128,
   parameter int NUM_REGS = 128,
   parameter int REG_AW   = 7,
   parameter int PC_W     = 11,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [31:0]       in_instr,
   input  logic              in_rrr,
   input  logic              in_wr_en,
   input  logic [1:0]        in_imm_sel,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [10:0]       out_opcode,
   output logic [REG_AW-1:0] out_dest,
   output logic              out_wr_en,
   output logic [REG_AW-1:0] out_ra_idx,
   output logic [REG_AW-1:0] out_rb_idx,
   output logic [DATA_W-1:0] out_ra,
   output logic [DATA_W-1:0] out_rb,
   output logic [DATA_W-1:0] out_rc,
   output logic [DATA_W-1:0] out_imm,
   output logic              stall_hazard,
   output logic [CNT_W-1:0]  hazard_cycles
);
   logic [DATA_W-1:0]   rf [NUM_REGS];
   logic [NUM_REGS-1:0] busy, set_mask, clr_mask;
   logic [REG_AW-1:0]   ra_idx, rb_idx, rc_idx, dest;
   logic                byp_a, byp_b, byp_c, byp_d, hazard, accept;
   logic [DATA_W-1:0]   ra_val, rb_val, rc_val;
   logic [31:0]         imm32;

   assign ra_idx = in_instr[13:7];
   assign rb_idx = in_instr[20:14];
   assign rc_idx = in_instr[6:0];
   assign dest   = in_rrr ? in_instr[27:21] : in_instr[6:0];

   assign byp_a  = wb_valid && wb_reg == ra_idx;
   assign byp_b  = wb_valid && wb_reg == rb_idx;
   assign byp_c  = wb_valid && wb_reg == rc_idx;
   assign byp_d  = wb_valid && wb_reg == dest;
   assign ra_val = byp_a ? wb_data : rf[ra_idx];
   assign rb_val = byp_b ? wb_data : rf[rb_idx];
   assign rc_val = byp_c ? wb_data : rf[rc_idx];

   // A writeback landing this cycle resolves the hazard it would otherwise cause.
   assign hazard = (busy[ra_idx] && !byp_a) || (busy[rb_idx] && !byp_b) ||
                   (in_rrr && busy[rc_idx] && !byp_c) || (in_wr_en && busy[dest] && !byp_d);
   assign in_ready     = (!out_valid || out_ready) && !hazard;
   assign accept       = in_valid && in_ready;
   assign stall_hazard = in_valid && hazard;

   assign set_mask = (accept && in_wr_en) ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << dest) : '0;
   assign clr_mask = wb_valid ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << wb_reg) : '0;

   always_comb begin
      imm32 = in_imm_sel == 2'd0 ? {{25{in_instr[20]}}, in_instr[20:14]} :
              in_imm_sel == 2'd1 ? {{22{in_instr[23]}}, in_instr[23:14]} :
              in_imm_sel == 2'd2 ? {{16{in_instr[22]}}, in_instr[22:7]} :
                                   {14'd0, in_instr[24:7]};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else if (wb_valid) begin
         rf[wb_reg] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy          <= '0;
         hazard_cycles <= '0;
      end else begin
         busy <= (busy & ~clr_mask) | set_mask;
         if (stall_hazard && !(&hazard_cycles)) hazard_cycles <= hazard_cycles + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid  <= 1'b0;
         out_pc     <= '0;
         out_opcode <= '0;
         out_dest   <= '0;
         out_wr_en  <= 1'b0;
         out_ra_idx <= '0;
         out_rb_idx <= '0;
         out_ra     <= '0;
         out_rb     <= '0;
         out_rc     <= '0;
         out_imm    <= '0;
      end else begin
         out_valid <= accept ? 1'b1 : (out_ready ? 1'b0 : out_valid);
         if (accept) begin
            out_pc     <= in_pc;
            out_opcode <= in_instr[31:21];
            out_dest   <= dest;
            out_wr_en  <= in_wr_en;
            out_ra_idx <= ra_idx;
            out_rb_idx <= rb_idx;
            out_ra     <= ra_val;
            out_rb     <= rb_val;
            out_rc     <= rc_val;
            out_imm    <= {(DATA_W/32){imm32}};
         end
      end
   end
endmodule

// File: tb/tb_spu_decode_stage.sv
// tb_spu_decode_stage: directed scenario tests for spu_decode_stage.
module tb_spu_decode_stage;
   logic         clk = 0, reset = 0;
   logic         in_valid = 0, in_ready, in_rrr = 0, in_wr_en = 0;
   logic [10:0]  in_pc = 0;
   logic [31:0]  in_instr = 0;
   logic [1:0]   in_imm_sel = 0;
   logic         wb_valid = 0;
   logic [6:0]   wb_reg = 0;
   logic [127:0] wb_data = 0;
   logic         out_valid, out_ready = 1, out_wr_en, stall_hazard;
   logic [10:0]  out_pc, out_opcode;
   logic [6:0]   out_dest, out_ra_idx, out_rb_idx;
   logic [127:0] out_ra, out_rb, out_rc, out_imm;
   logic [15:0]  hazard_cycles;
   int n_cmp = 0, n_err = 0;
   localparam logic [127:0] R5 = {16{8'h11}};

   spu_decode_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_instr(in_instr), .in_rrr(in_rrr), .in_wr_en(in_wr_en), .in_imm_sel(in_imm_sel),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode), .out_dest(out_dest),
      .out_wr_en(out_wr_en), .out_ra_idx(out_ra_idx), .out_rb_idx(out_rb_idx), .out_ra(out_ra),
      .out_rb(out_rb), .out_rc(out_rc), .out_imm(out_imm), .stall_hazard(stall_hazard),
      .hazard_cycles(hazard_cycles)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rr(input logic [10:0] op, input logic [6:0] rb, ra, rc);
      return {op, rb, ra, rc};
   endfunction

   task automatic test_reset;
      #12;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", out_valid); end
      n_cmp++; if (out_ra !== '0) begin n_err++; $display("FAIL rst_ra got %h exp 0", out_ra); end
      n_cmp++; if (hazard_cycles !== 16'd0) begin n_err++; $display("FAIL rst_hc got %0d exp 0", hazard_cycles); end
      @(negedge clk) reset = 1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_operands;
      @(negedge clk) begin wb_valid = 1; wb_reg = 5; wb_data = R5; end
      @(negedge clk) begin
         wb_valid = 0; in_valid = 1; in_pc = 11'h011; in_instr = rr(11'h123, 5, 5, 7'h2A);
      end
      @(posedge clk) #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL op_valid got %b exp 1", out_valid); end
      n_cmp++; if (out_ra !== R5) begin n_err++; $display("FAIL op_ra got %h exp %h", out_ra, R5); end
      n_cmp++; if (out_rb !== R5) begin n_err++; $display("FAIL op_rb got %h exp %h", out_rb, R5); end
      n_cmp++; if (out_dest !== 7'h2A) begin n_err++; $display("FAIL op_dest got %h exp 2a", out_dest); end
      n_cmp++; if (out_opcode !== 11'h123) begin n_err++; $display("FAIL op_opcode got %h exp 123", out_opcode); end
      n_cmp++; if (out_imm !== {4{32'h5}}) begin n_err++; $display("FAIL op_imm got %h exp 5x4", out_imm); end
      @(negedge clk) begin in_rrr = 1; in_pc = 11'h012; in_instr = rr(11'h033, 0, 0, 5); end
      @(posedge clk) #1;
      n_cmp++; if (out_rc !== R5) begin n_err++; $display("FAIL rrr_rc got %h exp %h", out_rc, R5); end
      n_cmp++; if (out_dest !== 7'h33) begin n_err++; $display("FAIL rrr_dest got %h exp 33", out_dest); end
      n_cmp++; if (out_pc !== 11'h012) begin n_err++; $display("FAIL rrr_pc got %h exp 012", out_pc); end
      @(negedge clk) begin in_valid = 0; in_rrr = 0; end
   endtask

   task automatic test_hazard;
      @(negedge clk) begin in_valid = 1; in_wr_en = 1; in_pc = 11'h200; in_instr = rr(11'h20, 0, 0, 9); end
      @(posedge clk) #1;
      n_cmp++; if (out_dest !== 7'd9) begin n_err++; $display("FAIL hz_dest got %0d exp 9", out_dest); end
      @(negedge clk) begin in_wr_en = 0; in_pc = 11'h201; in_instr = rr(11'h21, 1, 9, 10); end
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hz_ready got %b exp 0", in_ready); end
      n_cmp++; if (stall_hazard !== 1'b1) begin n_err++; $display("FAIL hz_stall got %b exp 1", stall_hazard); end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (hazard_cycles !== 16'd3) begin n_err++; $display("FAIL hz_count got %0d exp 3", hazard_cycles); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hz_bubble got %b exp 0", out_valid); end
      @(negedge clk) begin wb_valid = 1; wb_reg = 9; wb_data = 128'hAB; end
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hz_wb_ready got %b exp 1", in_ready); end
      @(posedge clk) #1;
      n_cmp++; if (out_ra !== 128'hAB) begin n_err++; $display("FAIL hz_bypass got %h exp ab", out_ra); end
      n_cmp++; if (out_pc !== 11'h201) begin n_err++; $display("FAIL hz_pc got %h exp 201", out_pc); end
      n_cmp++; if (hazard_cycles !== 16'd3) begin n_err++; $display("FAIL hz_count2 got %0d exp 3", hazard_cycles); end
      @(negedge clk) begin wb_valid = 0; in_valid = 0; end
   endtask

   task automatic test_imm;
      @(negedge clk) begin in_valid = 1; in_imm_sel = 0; in_instr = rr(11'h0, 7'h7F, 9, 0); end
      @(posedge clk) #1;
      n_cmp++; if (out_imm !== {4{32'hFFFFFFFF}}) begin n_err++; $display("FAIL imm7 got %h", out_imm); end
      n_cmp++; if (out_ra !== 128'hAB) begin n_err++; $display("FAIL rf_r9 got %h exp ab", out_ra); end
      @(negedge clk) begin in_imm_sel = 1; in_instr = 32'h0080_0000; end
      @(posedge clk) #1;
      n_cmp++; if (out_imm !== {4{32'hFFFFFE00}}) begin n_err++; $display("FAIL imm10 got %h", out_imm); end
      @(negedge clk) begin in_imm_sel = 2; in_instr = 32'h0040_0080; end
      @(posedge clk) #1;
      n_cmp++; if (out_imm !== {4{32'hFFFF8001}}) begin n_err++; $display("FAIL imm16 got %h", out_imm); end
      @(negedge clk) begin in_imm_sel = 3; in_instr = 32'h0100_0000; end
      @(posedge clk) #1;
      n_cmp++; if (out_imm !== {4{32'h00020000}}) begin n_err++; $display("FAIL imm18 got %h", out_imm); end
      @(negedge clk) begin in_valid = 0; in_imm_sel = 0; end
   endtask

   task automatic test_back_to_back;
      @(negedge clk) begin out_ready = 0; in_valid = 1; in_pc = 11'h101; in_instr = rr(11'h10, 0, 0, 0); end
      @(posedge clk);
      @(negedge clk) begin in_pc = 11'h102; in_instr = rr(11'h11, 0, 0, 0); end
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready[%0d] got %b exp 0", i, in_ready); end
         n_cmp++; if (out_pc !== 11'h101) begin n_err++; $display("FAIL hold_pc[%0d] got %h exp 101", i, out_pc); end
         n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d] got %b exp 1", i, out_valid); end
         @(negedge clk);
      end
      out_ready = 1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready got %b exp 1", in_ready); end
      @(posedge clk) #1;
      n_cmp++; if (out_pc !== 11'h102) begin n_err++; $display("FAIL b2b_pc1 got %h exp 102", out_pc); end
      @(negedge clk) begin in_pc = 11'h103; in_instr = rr(11'h12, 0, 0, 0); end
      @(posedge clk) #1;
      n_cmp++; if (out_pc !== 11'h103) begin n_err++; $display("FAIL b2b_pc2 got %h exp 103", out_pc); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got %b exp 1", out_valid); end
      @(negedge clk) in_valid = 0;
   endtask

   task automatic test_set_wins;
      @(negedge clk) begin in_valid = 1; in_wr_en = 1; in_pc = 11'h300; in_instr = rr(11'h30, 0, 0, 3); end
      @(negedge clk) begin in_pc = 11'h301; wb_valid = 1; wb_reg = 3; wb_data = 128'h33; end
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL sw_ready got %b exp 1", in_ready); end
      @(posedge clk) #1;
      n_cmp++; if (out_pc !== 11'h301) begin n_err++; $display("FAIL sw_pc got %h exp 301", out_pc); end
      @(negedge clk) begin wb_valid = 0; in_wr_en = 0; in_pc = 11'h302; in_instr = rr(11'h31, 0, 3, 0); end
      #1;
      n_cmp++; if (stall_hazard !== 1'b1) begin n_err++; $display("FAIL sw_busy got %b exp 1", stall_hazard); end
   endtask

   task automatic test_reset_mid_stall;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (hazard_cycles !== 16'd5) begin n_err++; $display("FAIL ms_count got %0d exp 5", hazard_cycles); end
      #2 reset = 0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ms_valid got %b exp 0", out_valid); end
      n_cmp++; if (hazard_cycles !== 16'd0) begin n_err++; $display("FAIL ms_hc got %0d exp 0", hazard_cycles); end
      n_cmp++; if (out_pc !== 11'd0) begin n_err++; $display("FAIL ms_pc got %h exp 0", out_pc); end
      @(negedge clk) reset = 1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ms_ready got %b exp 1", in_ready); end
      @(posedge clk) #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ms_accept got %b exp 1", out_valid); end
      n_cmp++; if (out_ra !== '0) begin n_err++; $display("FAIL ms_rf got %h exp 0", out_ra); end
      @(negedge clk) in_valid = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_operands();
      test_hazard();
      test_imm();
      test_back_to_back();
      test_set_wins();
      test_reset_mid_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
